// File: rtl/lp805x_presc_tick_if.sv
// Handshake bundle between the frequency-scale controller and the prescaler tick generator.
// The controller drives index loads and run control; the generator returns tick, phase and index status.
interface lp805x_presc_tick_if;
    logic [2:0] index;
    logic       index_ld;
    logic       enable;
    logic       clr;
    logic       tick;
    logic       phase;
    logic [2:0] cur_index;
    logic       pend;

    modport master (
        output index, index_ld, enable, clr,
        input  tick, phase, cur_index, pend
    );

    modport slave (
        input  index, index_ld, enable, clr,
        output tick, phase, cur_index, pend
    );
endinterface

// File: rtl/lp805x_presc_tick.sv
// Programmable tick generator: one-cycle tick and square phase every BASE_DIV<<(7-cur_index) clocks.
// Index loads are double-buffered so a period in progress is never truncated or stretched.
module lp805x_presc_tick #(
    parameter int BASE_DIV = 12,
    parameter int CNT_W    = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    lp805x_presc_tick_if.slave   bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;
    logic [2:0]       cur_q, cur_d;
    logic [2:0]       pend_idx_q, pend_idx_d;
    logic             pend_q, pend_d;

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_last;
    logic             wrap;

    assign period      = CNT_W'(BASE_DIV) << (3'd7 - cur_q);
    assign period_last = period - CNT_W'(1);
    assign wrap        = bus.enable && (cnt_q == period_last);

    // Next-state: clr first, then idle (no period to protect), then wrap, then normal counting.
    always_comb begin
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        phase_d    = phase_q;
        cur_d      = cur_q;
        pend_idx_d = pend_idx_q;
        pend_d     = pend_q;

        if (bus.clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            pend_d  = 1'b0;
            if (bus.index_ld) begin
                cur_d      = bus.index;
                pend_idx_d = bus.index;
            end else if (pend_q) begin
                cur_d = pend_idx_q;
            end
        end else if (!bus.enable) begin
            if (bus.index_ld) begin
                cur_d      = bus.index;
                pend_idx_d = bus.index;
                cnt_d      = '0;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                cur_d  = pend_idx_q;
                cnt_d  = '0;
                pend_d = 1'b0;
            end
        end else if (wrap) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            phase_d = ~phase_q;
            pend_d  = 1'b0;
            // A load landing on the wrap edge bypasses the buffer and sizes the new period.
            if (bus.index_ld) begin
                cur_d      = bus.index;
                pend_idx_d = bus.index;
            end else if (pend_q) begin
                cur_d = pend_idx_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.index_ld) begin
                pend_idx_d = bus.index;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            phase_q    <= 1'b0;
            cur_q      <= 3'd0;
            pend_idx_q <= 3'd0;
            pend_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
            cur_q      <= cur_d;
            pend_idx_q <= pend_idx_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.phase     = phase_q;
    assign bus.cur_index = cur_q;
    assign bus.pend      = pend_q;

endmodule
